// File: rtl/sonar_ping_ctrl.sv
// rtl/sonar_ping_ctrl.sv - sonar ping sequencer: TX burst, blanking, listen window, time of flight
module sonar_ping_ctrl #(
  parameter int CNT_W = 32,
  parameter int HP_W  = 16,
  parameter int NB_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [HP_W-1:0]  tx_half_period,
  input  logic [NB_W-1:0]  burst_cycles,
  input  logic [CNT_W-1:0] blank_cycles,
  input  logic [CNT_W-1:0] timeout_cycles,
  input  logic             echo_in,
  output logic             tx_out,
  output logic             tx_en,
  output logic             listen_en,
  output logic             busy,
  output logic             done,
  output logic             echo_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] tof
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_BLANK,
    S_LISTEN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NB_W:0]    half_one = {{NB_W{1'b0}}, 1'b1};
  localparam logic [HP_W-1:0]  hp_one   = {{(HP_W-1){1'b0}}, 1'b1};

  state_t state, state_next;

  // Configuration captured at start so register writes mid-ping are harmless
  logic [HP_W-1:0]  h_q;
  logic [NB_W-1:0]  n_q;
  logic [CNT_W-1:0] blank_q;
  logic [CNT_W-1:0] timeout_q;

  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] ph_cnt;    // clocks within a TX half-cycle, or within BLANK
  logic [NB_W:0]    half_cnt;  // completed TX half-cycles

  logic start_ok;
  logic ph_last;
  logic tx_last;
  logic blank_last;
  logic to_hit;

  assign start_ok   = (state == S_IDLE) && start && !abort;
  assign ph_last    = (ph_cnt == ({{(CNT_W-HP_W){1'b0}}, h_q} - cnt_one));
  assign tx_last    = ph_last && (half_cnt == ({n_q, 1'b0} - half_one));
  assign blank_last = (ph_cnt == (blank_q - cnt_one));
  assign to_hit     = (elapsed >= timeout_q);

  // Phase outputs are pure decodes of the state register, so they are registered
  // and drop straight away on asynchronous reset
  assign tx_en     = (state == S_TX);
  assign listen_en = (state == S_LISTEN);
  assign busy      = (state == S_TX) || (state == S_BLANK) || (state == S_LISTEN);
  assign done      = (state == S_DONE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic; abort overrides everything including start
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (burst_cycles != '0)      state_next = S_TX;
            else if (blank_cycles != '0) state_next = S_BLANK;
            else                         state_next = S_LISTEN;
          end
        end
        S_TX:     if (tx_last) state_next = (blank_q != '0) ? S_BLANK : S_LISTEN;
        S_BLANK:  if (blank_last) state_next = S_LISTEN;
        S_LISTEN: if (echo_in || to_hit) state_next = S_DONE;
        S_DONE:   state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Counters, TX square wave and measurement results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q        <= hp_one;
      n_q        <= '0;
      blank_q    <= '0;
      timeout_q  <= '0;
      elapsed    <= '0;
      ph_cnt     <= '0;
      half_cnt   <= '0;
      tx_out     <= 1'b0;
      echo_valid <= 1'b0;
      timeout    <= 1'b0;
      tof        <= '0;
    end else if (start_ok) begin
      h_q        <= (tx_half_period == '0) ? hp_one : tx_half_period;
      n_q        <= burst_cycles;
      blank_q    <= blank_cycles;
      timeout_q  <= timeout_cycles;
      elapsed    <= '0;
      ph_cnt     <= '0;
      half_cnt   <= '0;
      tx_out     <= (burst_cycles != '0);
      echo_valid <= 1'b0;
      timeout    <= 1'b0;
    end else if (abort) begin
      tx_out     <= 1'b0;
      echo_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (busy && (elapsed != '1)) elapsed <= elapsed + cnt_one;
      case (state)
        S_TX: begin
          if (ph_last) begin
            ph_cnt   <= '0;
            half_cnt <= half_cnt + half_one;
            tx_out   <= tx_last ? 1'b0 : ~tx_out;
          end else begin
            ph_cnt <= ph_cnt + cnt_one;
          end
        end
        S_BLANK: ph_cnt <= ph_cnt + cnt_one;
        S_LISTEN: begin
          if (echo_in) begin
            tof        <= elapsed;
            echo_valid <= 1'b1;
          end else if (to_hit) begin
            tof     <= timeout_q;
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_ping_ctrl.sv
// tb/tb_sonar_ping_ctrl.sv - directed table-driven bench for sonar_ping_ctrl
module tb_sonar_ping_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] tx_half_period = '0;
  logic [7:0]  burst_cycles = '0;
  logic [31:0] blank_cycles = '0;
  logic [31:0] timeout_cycles = '0;
  logic        echo_in = 1'b0;
  logic        tx_out, tx_en, listen_en, busy, done, echo_valid, timeout;
  logic [31:0] tof;

  sonar_ping_ctrl #(.CNT_W(32), .HP_W(16), .NB_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .tx_half_period(tx_half_period), .burst_cycles(burst_cycles),
    .blank_cycles(blank_cycles), .timeout_cycles(timeout_cycles),
    .echo_in(echo_in), .tx_out(tx_out), .tx_en(tx_en), .listen_en(listen_en),
    .busy(busy), .done(done), .echo_valid(echo_valid), .timeout(timeout), .tof(tof)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int h; int n; int b; int t;
    int echo_at;   // elapsed count where echo_in goes high, -1 for never
    int poke_k;    // elapsed count where start is pulsed and tx_half_period altered, -1 for never
    int e_tof; int e_ev; int e_to; int e_busy;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic begin_ping(input int h, input int n, input int b, input int t, input logic e0);
    @(negedge clk);
    tx_half_period = 16'(h);
    burst_cycles   = 8'(n);
    blank_cycles   = 32'(b);
    timeout_cycles = 32'(t);
    echo_in        = e0;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int he, tx_len, l_start, k, busy_cnt, wave_err;
    bit got_done;
    v        = vecs[i];
    he       = (v.h == 0) ? 1 : v.h;
    tx_len   = 2 * he * v.n;
    l_start  = tx_len + v.b;
    k        = 0;
    busy_cnt = 0;
    wave_err = 0;
    got_done = 0;
    begin_ping(v.h, v.n, v.b, v.t, v.echo_at == 0);
    while (k < 3000 && !got_done) begin
      if (done) begin
        got_done = 1;
      end else begin
        if (busy) busy_cnt++;
        if (tx_en !== (k < tx_len)) wave_err++;
        if (tx_out !== ((k < tx_len) && ((k / he) % 2 == 0))) wave_err++;
        if (listen_en !== (k >= l_start)) wave_err++;
        echo_in = (v.echo_at >= 0) && (k >= v.echo_at);
        if (k == v.poke_k) begin
          start          = 1'b1;
          tx_half_period = 16'd7;
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        #1;
        k++;
      end
    end
    start   = 1'b0;
    echo_in = 1'b0;
    check($sformatf("v%0d_done_seen", i), 64'(got_done), 64'd1);
    check($sformatf("v%0d_tof", i), 64'(tof), 64'(v.e_tof));
    check($sformatf("v%0d_echo_valid", i), 64'(echo_valid), 64'(v.e_ev));
    check($sformatf("v%0d_timeout", i), 64'(timeout), 64'(v.e_to));
    check($sformatf("v%0d_busy_cycles", i), 64'(busy_cnt), 64'(v.e_busy));
    check($sformatf("v%0d_waveform_errs", i), 64'(wave_err), 64'd0);
    @(posedge clk);
    #1;
    check($sformatf("v%0d_done_width", i), 64'(done), 64'd0);
  endtask

  initial begin
    //          h  n  b   t     echo poke tof ev to busy
    vecs[0] = '{2, 3, 10, 1000, 40,  -1,  40, 1, 0, 41};
    vecs[1] = '{1, 4, 5,  50,   -1,  -1,  50, 0, 1, 51};
    vecs[2] = '{0, 2, 3,  100,  7,   -1,  7,  1, 0, 8};
    vecs[3] = '{5, 0, 0,  20,   0,   -1,  0,  1, 0, 1};
    vecs[4] = '{3, 1, 0,  2,    -1,  -1,  2,  0, 1, 7};
    vecs[5] = '{1, 1, 2,  4,    4,   -1,  4,  1, 0, 5};
    vecs[6] = '{1, 0, 4,  10,   -1,  -1,  10, 0, 1, 11};
    vecs[7] = '{2, 3, 10, 1000, 40,  5,   40, 1, 0, 41};
    vecs[8] = '{2, 3, 10, 1000, 40,  30,  40, 1, 0, 41};

    // Reset state
    #12;
    check("rst_tx_out", 64'(tx_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_flags", 64'({tx_en, listen_en, done, echo_valid, timeout}), 64'd0);
    check("rst_tof", 64'(tof), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i);

    // Abort during BLANK of a nominal ping
    begin_ping(2, 3, 10, 1000, 1'b0);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    check("abort_pre_busy", 64'(busy), 64'd1);
    check("abort_pre_phase", 64'({tx_en, listen_en}), 64'd0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_outs", 64'({tx_out, tx_en, listen_en}), 64'd0);
    check("abort_flags", 64'({echo_valid, timeout}), 64'd0);
    check("abort_tof_kept", 64'(tof), 64'd40);
    begin
      bit seen;
      seen = 0;
      repeat (40) begin
        if (done || busy) seen = 1;
        @(posedge clk);
        #1;
      end
      check("abort_no_done", 64'(seen), 64'd0);
    end
    run_vec(0);

    // start and abort together in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    check("start_abort_tx_en", 64'(tx_en), 64'd0);

    // Asynchronous reset mid-TX
    begin_ping(4, 4, 5, 500, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("mid_tx_tx_out", 64'(tx_out), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_tx_out", 64'(tx_out), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_tof", 64'(tof), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vec(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sonar_ping_ctrl.md
# sonar_ping_ctrl

Ping sequencer for the sonar receive chain. One measurement per `start`:
- drives a transmit burst to the transducer;
- blanks the receiver while ring-down decays;
- enables the listen window (PCM capture / moving-average path);
- times the first assertion of the threshold comparator output, giving the time of flight in clock cycles, or flags a timeout.

It sits between the Wishbone control registers and the comparator/PCM datapath of the sonar top level.

## Interface
Parameters:
- `CNT_W`, 32, width of the elapsed/TOF counter and the timing configuration words
- `HP_W`, 16, width of the transmit half-period
- `NB_W`, 8, width of the burst-period count

Ports:
- `clk`  in  1  system clock (Wishbone clock)
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a ping; honoured in IDLE only
- `abort`  in  1  terminate any ping; return to IDLE
- `tx_half_period`  in  HP_W  clocks per transmit half-cycle; 0 is treated as 1
- `burst_cycles`  in  NB_W  number of full transmit periods; 0 means no TX phase
- `blank_cycles`  in  CNT_W  blanking length in clocks
- `timeout_cycles`  in  CNT_W  maximum elapsed count before timeout
- `echo_in`  in  1  comparator output; synchronous to `clk`
- `tx_out`  out  1  transducer drive square wave
- `tx_en`  out  1  high during the TX phase
- `listen_en`  out  1  high during the LISTEN phase; enables PCM register and filter path
- `busy`  out  1  high in TX, BLANK and LISTEN
- `done`  out  1  one-cycle pulse when a ping completes (echo or timeout)
- `echo_valid`  out  1  last ping detected an echo
- `timeout`  out  1  last ping timed out
- `tof`  out  CNT_W  elapsed count at echo, or `timeout_cycles` value on timeout

## Operation
- States: IDLE, TX, BLANK, LISTEN, DONE.
- Reset (rst=0): state IDLE.
  - Outputs `tx_out`, `tx_en`, `listen_en`, `busy`, `done`, `echo_valid`, `timeout` = 0.
  - `tof` = 0.
- IDLE, `start`=1, `abort`=0:
  - Latch all four configuration inputs. Later changes to them have no effect until the next start.
  - Clear `echo_valid` and `timeout`.
  - Elapsed counter := 0.
  - Next state: TX, or BLANK if `burst_cycles`=0, or LISTEN if `burst_cycles`=0 and `blank_cycles`=0.
- Elapsed counter:
  - Is 0 in the first cycle after start.
  - Increments by 1 every cycle while `busy`.
  - Saturates at all-ones.
- TX:
  - `tx_out` starts at 1 and toggles every H clocks, where H = max(`tx_half_period`, 1).
  - Leaves after 2·H·N cycles (N = `burst_cycles`).
  - `tx_out`=0 outside TX.
- BLANK: lasts `blank_cycles` cycles, then LISTEN.
- LISTEN, evaluated each cycle:
  - If `echo_in`=1: `tof` := elapsed count of this cycle, `echo_valid`:=1, go to DONE.
  - Else if elapsed ≥ latched `timeout_cycles`: `tof` := `timeout_cycles`, `timeout`:=1, go to DONE.
  - Echo has priority over timeout in the same cycle.
  - `echo_in` is a level, not an edge: if high on the first LISTEN cycle, the echo is detected immediately.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `tof`, `echo_valid` and `timeout` hold until the next accepted start, abort or reset.
- `abort`=1 in any state:
  - Next cycle is IDLE, with `tx_out`/`tx_en`/`listen_en`/`busy` = 0.
  - No `done` pulse.
  - `echo_valid` and `timeout` cleared; `tof` unchanged.
  - `abort` beats `start` in the same cycle.
- `start` outside IDLE is ignored. No queueing.
- `start` held high: a new ping begins in the cycle after DONE returns to IDLE. IDLE lasts one cycle.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- Start latency: `start` sampled at edge t → `busy`, `tx_en`, `tx_out`=1 visible after edge t.
- Echo latency: `echo_in` sampled high in LISTEN at edge t → `done`, `echo_valid`, `tof` updated after edge t, together.
- Time of flight is measured from the first TX cycle.
- LISTEN begins at elapsed count 2·H·N + `blank_cycles`.
- Timeout when LISTEN begins with `timeout_cycles` ≤ that value: the timeout fires in the first LISTEN cycle.
- Asynchronous reset mid-ping: all outputs return to reset values immediately, regardless of `clk`.

## Test plan
- **Nominal echo.**
  - Stimulus: H=2, N=3, blank=10, timeout=1000; `echo_in` raised at elapsed 40.
  - Response:
    - `tx_out` = 1,1,0,0 repeated ×3 (12 cycles);
    - `listen_en` rises at elapsed 22;
    - `done` pulse; `tof`=40, `echo_valid`=1, `timeout`=0.
- **Timeout.**
  - Stimulus: H=1, N=4, blank=5, timeout=50; `echo_in`=0.
  - Response: `done` pulse; `tof`=50, `timeout`=1, `echo_valid`=0; `busy` high for 51 cycles.
- **Degenerate configuration.**
  - Stimulus: N=0, blank=0, `echo_in`=1 at start.
  - Response: `tx_en` never high; `tof`=0, `echo_valid`=1, DONE two cycles after start.
- **Abort.**
  - Stimulus: abort during BLANK of a nominal ping.
  - Response:
    - IDLE next cycle; no `done`; flags cleared; `tof` keeps the previous value;
    - a subsequent start runs normally.
- **Ignored inputs.**
  - Stimulus: start pulsed during LISTEN; `tx_half_period` changed during TX.
  - Response: no restart; TX waveform unchanged.
- **Reset and priority.**
  - Stimulus: `rst` low asserted asynchronously mid-TX.
  - Response: `tx_out`, `busy` drop without a clock edge.
  - Stimulus: `start` and `abort` together in IDLE.
  - Response: stays IDLE.
